uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLK_FREQ, 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, 9600, serial bit rate.
REQ-003 Parameter DEPTH, 16, receive FIFO entries (power of two, at least 2).
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx  input  1  asynchronous UART serial line; idles high; 8N1 framing, LSB first.
REQ-007 rd_en  input  1  pop request from the consumer.
REQ-008 data_out  output  8  byte popped by the last accepted rd_en.
REQ-009 rd_valid  output  1  one-cycle pulse; marks data_out as newly updated.
REQ-010 empty  output  1  FIFO holds zero bytes.
REQ-011 full  output  1  FIFO holds DEPTH bytes.
REQ-012 count  output  log2(DEPTH)+1  number of bytes held.
REQ-013 frame_err  output  1  one-cycle pulse; the stop bit sampled low.
REQ-014 overrun  output  1  one-cycle pulse; a received byte was dropped because the FIFO was full.

Function
REQ-015 rx shall pass through a 2-flop synchronizer before any other use; both flops reset to 1.
REQ-016 The tick generator shall pulse once every DIV = CLK_FREQ/(BAUD*16) clocks, using integer floor division (DIV = 325 at the defaults).
REQ-017 The tick counter shall run only outside IDLE and shall restart from 0 on entry to START.
REQ-018 The FSM shall have four states: IDLE, START, DATA and STOP.
REQ-019 IDLE -> START shall occur on a synchronized 1->0 transition of rx.
REQ-020 In START, rx shall be sampled at tick 8; if low, go to DATA with the bit index at 0; if high (false start), return to IDLE with nothing pushed and no error flagged.
REQ-021 In DATA, rx shall be sampled every 16 ticks, each sample shifted into bit position 0..7 in order; after bit 7, go to STOP.
REQ-022 In STOP, rx shall be sampled 16 ticks after bit 7.
REQ-023 If the stop sample is high, the assembled byte shall be pushed to the FIFO; if low, frame_err shall pulse, the byte shall be discarded, and the FSM shall go to IDLE.
REQ-024 After any frame, IDLE shall start a new frame only on a fresh 1->0 transition, so a held-low line (break) causes no repeated frames.
REQ-025 A push while full shall drop the byte, pulse overrun, and leave the FIFO contents unchanged.
REQ-026 rd_en while not empty shall load data_out from the head entry on that edge, advance the read pointer and pulse rd_valid the next cycle, giving one-cycle read latency.
REQ-027 rd_en while empty shall be ignored: data_out is held and rd_valid stays 0.
REQ-028 A simultaneous push and accepted pop shall both complete with count unchanged; this holds when full (no overrun) and when count is 1.
REQ-029 A simultaneous push and rd_en while empty shall perform the push only.
REQ-030 Pointers shall wrap modulo DEPTH.
REQ-031 full, empty and count shall be registered and shall reflect an operation in the cycle after that operation's edge.
REQ-032 The bytes read shall match the order received, with no duplication or loss except the overrun drops of REQ-025.

Reset
REQ-033 While reset is asserted: FSM in IDLE; tick counter, bit index and shift register at 0; synchronizer at 1.
REQ-034 While reset is asserted, the FIFO shall be empty: pointers 0, count 0, empty=1, full=0.
REQ-035 While reset is asserted: data_out=8'h00, rd_valid=0, frame_err=0, overrun=0.
REQ-036 Reset asserted mid-frame shall abandon the partial byte without pushing it or flagging an error.
REQ-037 After reset deasserts, the block shall not start a frame until rx has been seen high and then falls.

Verification
REQ-038 Byte 0xA5 sent at 9600 baud (5200 clk/bit) -> empty falls about 9.5 bit times (49400 +/- 5 clk) after the start edge, count=1; one rd_en -> rd_valid pulse with data_out=8'hA5, then empty=1.
REQ-039 Bytes 0x00, 0xFF, 0x3C sent back-to-back with no rd_en -> count=3; three reads return them in that order.
REQ-040 Frame 0x55 with its stop bit forced low -> one frame_err pulse, count stays 0; a following good 0x12 is received correctly.
REQ-041 A 2-bit-time (10400 clk) low glitch on rx -> false-start rejection, or frame_err if the glitch extends into the stop sample; in neither case is 8'h00 pushed when the stop sample is low.
REQ-042 DEPTH+1 bytes sent without reads -> full=1, one overrun pulse on the last byte; reads return the first DEPTH bytes in order and the pointers have wrapped.
REQ-043 Reset pulsed midway through bit 4 of a frame -> all outputs at their reset values, count=0, no push; the next full frame is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : 8N1 UART receiver (16x oversampling, mid-bit sampling) feeding
//             a DEPTH-entry byte FIFO with registered status flags.
//  Ports    : clk       - system clock, all logic on its rising edge
//             reset     - asynchronous, active-high reset
//             rx        - asynchronous serial line, idles high, LSB first
//             rd_en     - pop request from the consumer
//             data_out  - byte popped by the last accepted rd_en
//             rd_valid  - one-cycle pulse, data_out newly updated
//             empty     - FIFO holds zero bytes
//             full      - FIFO holds DEPTH bytes
//             count     - number of bytes held
//             frame_err - one-cycle pulse, stop bit sampled low
//             overrun   - one-cycle pulse, byte dropped because FIFO full
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx,
    input  logic                     rd_en,
    output logic [7:0]               data_out,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_err,
    output logic                     overrun
);

    localparam int c_DIV = CLK_FREQ / (BAUD * 16);
    localparam int c_TW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_AW  = $clog2(DEPTH);
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(c_DIV - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    // ------------------------------------------------------------------ receiver
    logic            r_rx_meta, r_rx_sync;
    logic [1:0]      r_primed;
    logic            r_armed;
    logic [1:0]      r_state, w_state_nxt;
    logic [c_TW-1:0] r_tick_cnt;
    logic [3:0]      r_sub;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            w_tick, w_shift_en, w_push, w_ferr;

    always_comb begin
        w_tick      = (r_state != c_IDLE) && (r_tick_cnt == c_TICK_LAST);
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_push      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            c_IDLE: begin
                // Armed only after the line was genuinely seen high in IDLE,
                // so a line held low (break, or low out of reset) never starts a frame.
                if (r_armed && !r_rx_sync) w_state_nxt = c_START;
            end
            c_START: begin
                if (w_tick && r_sub == 4'd7) w_state_nxt = r_rx_sync ? c_IDLE : c_DATA;
            end
            c_DATA: begin
                if (w_tick && r_sub == 4'd15) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) w_state_nxt = c_STOP;
                end
            end
            c_STOP: begin
                if (w_tick && r_sub == 4'd15) begin
                    w_state_nxt = c_IDLE;
                    if (r_rx_sync) w_push = 1'b1;
                    else           w_ferr = 1'b1;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_primed   <= 2'b00;
            r_armed    <= 1'b0;
            r_state    <= c_IDLE;
            r_tick_cnt <= '0;
            r_sub      <= 4'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            // r_primed[1] marks the synchronizer as holding a real line sample
            r_primed  <= {r_primed[0], 1'b1};
            r_armed   <= (r_state == c_IDLE) && r_rx_sync && r_primed[1];
            r_state   <= w_state_nxt;

            if (r_state == c_IDLE || w_tick) r_tick_cnt <= '0;
            else                             r_tick_cnt <= r_tick_cnt + 1'b1;

            // Oversample counter restarts on every state change
            if (w_state_nxt != r_state) r_sub <= 4'd0;
            else if (w_tick)            r_sub <= r_sub + 4'd1;

            if (r_state == c_START)  r_bit_idx <= 3'd0;
            else if (w_shift_en)     r_bit_idx <= r_bit_idx + 3'd1;

            if (w_shift_en) r_shift <= {r_rx_sync, r_shift[7:1]};
        end
    end

    // ---------------------------------------------------------------------- fifo
    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]   r_count, w_count_nxt;
    logic            r_empty, r_full;
    logic [7:0]      r_data_out;
    logic            r_rd_valid, r_frame_err, r_overrun;
    logic            w_pop, w_wr, w_ovr;

    // A pop in the same cycle frees a slot, so a push while full still lands.
    always_comb begin
        w_pop       = rd_en && !r_empty;
        w_wr        = w_push && (!r_full || w_pop);
        w_ovr       = w_push && r_full && !w_pop;
        w_count_nxt = r_count;
        if (w_wr && !w_pop)      w_count_nxt = r_count + 1'b1;
        else if (!w_wr && w_pop) w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_data_out  <= 8'h00;
            r_rd_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_data_out <= r_mem[r_rd_ptr];
            end
            r_count     <= w_count_nxt;
            r_empty     <= (w_count_nxt == '0);
            r_full      <= (w_count_nxt == (c_AW+1)'(DEPTH));
            r_rd_valid  <= w_pop;
            r_frame_err <= w_ferr;
            r_overrun   <= w_ovr;
        end
    end

    assign data_out  = r_data_out;
    assign rd_valid  = r_rd_valid;
    assign empty     = r_empty;
    assign full      = r_full;
    assign count     = r_count;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
